// File: rtl/pll_lock_sequencer_pkg.sv
// Shared definitions for the PLL lock sequencer.
//   pll_state_e : state encodings, also driven out on the 3-bit state port
//   clog2       : elaboration-time ceiling log2, used to size the dwell counter
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_e;

  // Number of bits needed to hold values 0..v-1 (at least 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Status/control bundle between the lock sequencer and its surroundings.
//   locked          : raw PLL LOCK (asynchronous to the reference clock)
//   restart         : one-cycle request to re-run the whole sequence
//   pll_resetb      : PLL RESETB, low holds the PLL in reset
//   sys_reset       : system reset request, high until lock is qualified
//   ready / fault   : RUN / FAULT indicators
//   state           : current state encoding
//   retries         : PLL reset retries used in the current attempt
//   lock_loss_count : saturating count of lock losses seen while running
// slave is the sequencer side, master is the side that owns locked/restart.
interface pll_lock_sequencer_if;
  logic       locked;
  logic       restart;
  logic       pll_resetb;
  logic       sys_reset;
  logic       ready;
  logic       fault;
  logic [2:0] state;
  logic [3:0] retries;
  logic [7:0] lock_loss_count;

  modport slave (
    input  locked, restart,
    output pll_resetb, sys_reset, ready, fault, state, retries, lock_loss_count
  );

  modport master (
    output locked, restart,
    input  pll_resetb, sys_reset, ready, fault, state, retries, lock_loss_count
  );
endinterface

// File: rtl/pll_lock_sequencer_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk : destination clock
//   rst : synchronous active-high reset, clears both flops to 0
//   d   : asynchronous input
//   q   : synchronized output (second flop)
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Power-up / re-lock sequencer for the iCE40 system PLL.
// Pulses PLL RESETB, waits for LOCK, qualifies it for LOCK_STABLE cycles and
// only then releases the system reset request. A PLL that does not lock within
// LOCK_TIMEOUT is reset again, up to MAX_RETRIES times, after which FAULT is
// latched. Lock losses while running are counted (saturating) and the PLL is
// left to re-lock on its own.
//   clock_in : 24 MHz reference, the only clock
//   reset    : synchronous, active-high
//   bus      : pll_lock_sequencer_if.slave (locked/restart in, status out)
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RESET_PULSE  = 16,
  parameter int LOCK_TIMEOUT = 24000,
  parameter int LOCK_STABLE  = 2400,
  parameter int MAX_RETRIES  = 3
) (
  input  logic                 clock_in,
  input  logic                 reset,
  pll_lock_sequencer_if.slave  bus
);

  localparam int MAX_P   = (RESET_PULSE > LOCK_TIMEOUT)
                           ? ((RESET_PULSE > LOCK_STABLE) ? RESET_PULSE : LOCK_STABLE)
                           : ((LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE);
  localparam int CNT_RAW = clog2(MAX_P);
  localparam int CNT_W   = (CNT_RAW < 16) ? 16 : CNT_RAW;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_PULSE - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  logic             lock_s;
  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retries_q, retries_d;
  logic [7:0]       llc_q, llc_d;
  logic             pll_resetb_q, pll_resetb_d;
  logic             sys_reset_q, sys_reset_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;

  sync2 u_lock_sync (
    .clk (clock_in),
    .rst (reset),
    .d   (bus.locked),
    .q   (lock_s)
  );

  // State register: FSM state, dwell counter, retry/loss counters and the
  // registered output decode all update on the same edge.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q      <= ST_PLL_RST;
      cnt_q        <= '0;
      retries_q    <= '0;
      llc_q        <= '0;
      pll_resetb_q <= 1'b0;
      sys_reset_q  <= 1'b1;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retries_q    <= retries_d;
      llc_q        <= llc_d;
      pll_resetb_q <= pll_resetb_d;
      sys_reset_q  <= sys_reset_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
    end
  end

  // Next-state logic. restart overrides every transition.
  always_comb begin
    state_d   = state_q;
    retries_d = retries_q;
    llc_d     = llc_q;
    cnt_d     = cnt_q + 1'b1;

    if (bus.restart) begin
      state_d   = ST_PLL_RST;
      retries_d = '0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
          end else if (cnt_q == TO_LAST) begin
            if (retries_q == RETRY_MAX) begin
              state_d = ST_FAULT;
            end else begin
              retries_d = retries_q + 4'd1;
              state_d   = ST_PLL_RST;
            end
          end
        end
        ST_STABLE: begin
          // Any low sample restarts qualification via WAIT_LOCK.
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == STB_LAST) begin
            state_d   = ST_RUN;
            retries_d = '0;
          end
        end
        ST_RUN: begin
          // No PLL reset here: the iCE40 PLL re-acquires lock by itself.
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            if (llc_q != 8'hFF) llc_d = llc_q + 8'd1;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_PLL_RST;
        end
      endcase
    end

    // The counter is meaningless in RUN/FAULT, so hold it there rather than
    // let it toggle; it always restarts from 0 on entry to any state.
    if ((state_q == ST_RUN || state_q == ST_FAULT) && !bus.restart) cnt_d = cnt_q;
    if (bus.restart || (state_d != state_q)) cnt_d = '0;
  end

  // Output decode from next state, so outputs are registered and move with state.
  always_comb begin
    pll_resetb_d = !((state_d == ST_PLL_RST) || (state_d == ST_FAULT));
    sys_reset_d  = (state_d != ST_RUN);
    ready_d      = (state_d == ST_RUN);
    fault_d      = (state_d == ST_FAULT);
  end

  assign bus.pll_resetb      = pll_resetb_q;
  assign bus.sys_reset       = sys_reset_q;
  assign bus.ready           = ready_q;
  assign bus.fault           = fault_q;
  assign bus.state           = state_q;
  assign bus.retries         = retries_q;
  assign bus.lock_loss_count = llc_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
module tb_pll_lock_sequencer;

  localparam int RP = 4;
  localparam int LT = 20;
  localparam int LS = 8;
  localparam int MR = 2;

  localparam int S_RST = 0, S_WAIT = 1, S_STB = 2, S_RUN = 3, S_FLT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pll_lock_sequencer_if bus ();

  pll_lock_sequencer #(
    .RESET_PULSE  (RP),
    .LOCK_TIMEOUT (LT),
    .LOCK_STABLE  (LS),
    .MAX_RETRIES  (MR)
  ) dut (
    .clock_in (clk),
    .reset    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- behavioural model ----------------
  // State dwell is tracked as "edge at which the state was entered"; a rule
  // that fires after N cycles in a state fires on the N-th edge after entry.
  int m_cyc = 0, m_entry = 0, m_st = S_RST, m_ret = 0, m_llc = 0;
  bit m_valid = 0;
  bit m_sync0 = 0, m_sync1 = 0, m_ls;
  int dwell;

  function automatic void enter(input int s);
    m_st    = s;
    m_entry = m_cyc;
  endfunction

  always @(posedge clk) begin
    m_cyc++;
    m_ls = m_sync1;
    if (rst) begin
      m_sync0 = 0; m_sync1 = 0;
      enter(S_RST); m_ret = 0; m_llc = 0; m_valid = 1;
    end else begin
      m_sync1 = m_sync0;
      m_sync0 = bus.locked;
      dwell   = m_cyc - m_entry;
      if (bus.restart) begin
        enter(S_RST); m_ret = 0;
      end else begin
        case (m_st)
          S_RST:  if (dwell == RP) enter(S_WAIT);
          S_WAIT: if (m_ls) enter(S_STB);
                  else if (dwell == LT) begin
                    if (m_ret == MR) enter(S_FLT);
                    else begin m_ret++; enter(S_RST); end
                  end
          S_STB:  if (!m_ls) enter(S_WAIT);
                  else if (dwell == LS) begin enter(S_RUN); m_ret = 0; end
          S_RUN:  if (!m_ls) begin enter(S_WAIT); if (m_llc < 255) m_llc++; end
          default: ;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      logic [17:0] act, exp;
      act = {bus.state, bus.retries, bus.lock_loss_count,
             bus.pll_resetb, bus.sys_reset, bus.ready, bus.fault};
      exp = {3'(m_st), 4'(m_ret), 8'(m_llc),
             1'(m_st != S_RST && m_st != S_FLT), 1'(m_st != S_RUN),
             1'(m_st == S_RUN), 1'(m_st == S_FLT)};
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t actual st=%0d ret=%0d llc=%0d rb/sr/rdy/flt=%b required st=%0d ret=%0d llc=%0d rb/sr/rdy/flt=%b",
                 $time, act[17:15], act[14:11], act[10:3], act[3:0],
                 exp[17:15], exp[14:11], exp[10:3], exp[3:0]);
      end
    end
  end

  // ---------------- directed literal checks ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int hold;

  initial begin
    bus.locked  = 1'b1;
    bus.restart = 1'b0;
    rst         = 1'b1;

    // Power-up with lock already present.
    step(3);
    chk("rst_state", bus.state, 0);
    chk("rst_pll_resetb", bus.pll_resetb, 0);
    chk("rst_sys_reset", bus.sys_reset, 1);
    chk("rst_ready", bus.ready, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_retries", bus.retries, 0);
    chk("rst_llc", bus.lock_loss_count, 0);
    rst = 1'b0;
    step(3);
    chk("pu_resetb_low", bus.pll_resetb, 0);
    step(1);
    chk("pu_wait", bus.state, 1);
    chk("pu_resetb_high", bus.pll_resetb, 1);
    step(1);
    chk("pu_stable", bus.state, 2);
    step(7);
    chk("pu_still_stable", bus.sys_reset, 1);
    step(1);
    chk("pu_run", bus.state, 3);
    chk("pu_sys_reset", bus.sys_reset, 0);
    chk("pu_ready", bus.ready, 1);
    chk("pu_retries", bus.retries, 0);

    // Never locks: retries then FAULT, restart leaves FAULT.
    rst = 1'b1; bus.locked = 1'b0;
    step(2);
    rst = 1'b0;
    step(24);
    chk("nl_retry1_state", bus.state, 0);
    chk("nl_retry1_cnt", bus.retries, 1);
    step(47);
    chk("nl_last_wait", bus.state, 1);
    step(1);
    chk("nl_fault_state", bus.state, 4);
    chk("nl_fault", bus.fault, 1);
    chk("nl_fault_resetb", bus.pll_resetb, 0);
    chk("nl_fault_retries", bus.retries, 2);
    step(10);
    chk("nl_fault_hold", bus.state, 4);
    bus.restart = 1'b1;
    step(1);
    bus.restart = 1'b0;
    chk("nl_restart_state", bus.state, 0);
    chk("nl_restart_fault", bus.fault, 0);
    chk("nl_restart_retries", bus.retries, 0);

    // Lock appears during the second WAIT_LOCK.
    rst = 1'b1; bus.locked = 1'b0;
    step(2);
    rst = 1'b0;
    step(30);
    bus.locked = 1'b1;
    step(2);
    chk("l2_wait", bus.state, 1);
    step(1);
    chk("l2_stable", bus.state, 2);
    chk("l2_retries", bus.retries, 1);
    step(7);
    chk("l2_not_yet", bus.state, 2);
    step(1);
    chk("l2_run", bus.state, 3);
    chk("l2_retries_clr", bus.retries, 0);

    // Lock lost for 3 cycles while running.
    bus.locked = 1'b0;
    step(2);
    chk("ll_still_run", bus.sys_reset, 0);
    step(1);
    chk("ll_sys_reset", bus.sys_reset, 1);
    chk("ll_wait", bus.state, 1);
    chk("ll_count", bus.lock_loss_count, 1);
    chk("ll_resetb", bus.pll_resetb, 1);
    bus.locked = 1'b1;
    step(2);
    chk("ll_wait2", bus.state, 1);
    step(1);
    chk("ll_stable", bus.state, 2);
    step(8);
    chk("ll_run", bus.state, 3);

    // One-cycle glitch from RUN, then a glitch at counter 5 in STABLE.
    bus.locked = 1'b0;
    step(1);
    bus.locked = 1'b1;
    step(2);
    chk("gl_wait", bus.state, 1);
    chk("gl_count", bus.lock_loss_count, 2);
    step(1);
    chk("gl_stable", bus.state, 2);
    step(3);
    bus.locked = 1'b0;
    step(1);
    bus.locked = 1'b1;
    step(1);
    chk("gl_stable_pre", bus.state, 2);
    step(1);
    chk("gl_requal_wait", bus.state, 1);
    step(1);
    chk("gl_requal_stable", bus.state, 2);
    step(7);
    chk("gl_no_early_run", bus.state, 2);
    step(1);
    chk("gl_run", bus.state, 3);

    // Saturate the lock-loss counter.
    for (int i = 0; i < 260; i++) begin
      bus.locked = 1'b0;
      step(1);
      bus.locked = 1'b1;
      step(11);
    end
    chk("sat_run", bus.state, 3);
    chk("sat_llc", bus.lock_loss_count, 255);
    bus.restart = 1'b1;
    step(1);
    bus.restart = 1'b0;
    chk("sat_restart_state", bus.state, 0);
    chk("sat_restart_llc", bus.lock_loss_count, 255);
    rst = 1'b1; bus.restart = 1'b1;
    step(1);
    chk("both_state", bus.state, 0);
    chk("both_llc", bus.lock_loss_count, 0);
    chk("both_resetb", bus.pll_resetb, 0);
    chk("both_sys_reset", bus.sys_reset, 1);
    chk("both_retries", bus.retries, 0);
    rst = 1'b0; bus.restart = 1'b0;

    // Randomised phase, checked cycle by cycle against the model.
    for (int i = 0; i < 150; i++) begin
      bus.locked = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) hold = $urandom_range(40, 100);
      else hold = $urandom_range(1, 14);
      for (int j = 0; j < hold; j++) begin
        bus.restart = ($urandom_range(0, 59) == 0);
        rst         = ($urandom_range(0, 399) == 0);
        step(1);
      end
    end
    bus.restart = 1'b0;
    rst = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
